// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART memory bridge: parser states, command and
// response byte codes, and a byte-select helper for the response buffer.
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_MEM,
    S_TX
  } state_e;

  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] RSP_ACK = 8'h2E;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  // Value the UART data register reads as when its receive buffer is empty.
  localparam logic [31:0] UART_EMPTY = 32'hFFFF_FFFF;

  // Byte lane idx of a word, lane 0 being bits [7:0].
  function automatic logic [7:0] pickByte(input logic [31:0] word, input logic [1:0] idx);
    pickByte = word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_bridge_rxpoll.sv
// Receive side of the bridge: watches the UART data register, consumes one
// byte at a time and hands it to the parser as a one-cycle byte_valid strobe.
// After each consume pulse one cycle is skipped, because the UART's valid
// flag only drops a cycle after the consume.
module uart_bridge_rxpoll
  import uart_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        poll_en_i,
  input  logic [31:0] reg_dat_do,
  output logic        reg_dat_re,
  output logic        byte_valid,
  output logic [7:0]  byte_data
);

  logic       re_q, re_d;
  logic       skip_q, skip_d;
  logic [7:0] data_q, data_d;

  // Decide whether to take a byte this cycle; never sample during the pulse or the skip cycle.
  always_comb begin
    re_d   = 1'b0;
    skip_d = re_q;
    data_d = data_q;
    if (poll_en_i && !re_q && !skip_q && (reg_dat_do != UART_EMPTY)) begin
      re_d   = 1'b1;
      data_d = reg_dat_do[7:0];
    end
  end

  // Consume pulse, skip flag and captured byte registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      re_q   <= 1'b0;
      skip_q <= 1'b0;
      data_q <= 8'h00;
    end else begin
      re_q   <= re_d;
      skip_q <= skip_d;
      data_q <= data_d;
    end
  end

  assign reg_dat_re = re_q;
  assign byte_valid = re_q;
  assign byte_data  = data_q;

endmodule

// File: rtl/uart_mem_bridge.sv
// UART debug bridge: parses 'R'/'W' byte commands from the UART register port,
// performs one 32-bit access on the native memory bus and sends the reply
// bytes back through the UART. All outputs are registered so they read 0
// while in reset. Optional macro UART_BRIDGE_TIMEOUT_EN adds an inter-byte
// timeout that silently abandons a half-received command.
module uart_mem_bridge #(
  parameter int DIVIDER = 104,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [3:0]  reg_div_we,
  output logic [31:0] reg_div_di,
  output logic        reg_dat_we,
  output logic        reg_dat_re,
  output logic [31:0] reg_dat_di,
  input  logic [31:0] reg_dat_do,
  input  logic        reg_dat_wait,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  import uart_bridge_pkg::*;

  state_e      state_q, state_d;
  logic        isWr_q, isWr_d;
  logic [1:0]  byteCnt_q, byteCnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_q, rsp_d;
  logic [1:0]  rspLast_q, rspLast_d;
  logic [1:0]  txCnt_q, txCnt_d;
  logic [3:0]  divWe_q, divWe_d;
  logic [31:0] divDi_q, divDi_d;
  logic        datWe_q, datWe_d;
  logic [7:0]  datDi_q, datDi_d;
  logic        memValid_q, memValid_d;
  logic [31:0] memAddr_q, memAddr_d;
  logic [31:0] memWdata_q, memWdata_d;
  logic [3:0]  memWstrb_q, memWstrb_d;

  logic        pollEn;
  logic        byteValid;
  logic [7:0]  byteData;
  logic [31:0] addrShift;
  logic [31:0] wdataShift;

`ifdef UART_BRIDGE_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
`else
  localparam int unusedTimeout = TIMEOUT;
`endif

  // Bytes are only taken from the UART while a command is being parsed.
  assign pollEn     = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign addrShift  = {byteData, addr_q[31:8]};
  assign wdataShift = {byteData, wdata_q[31:8]};

  uart_bridge_rxpoll u_rxpoll (
    .clk        (clk),
    .resetn     (resetn),
    .poll_en_i  (pollEn),
    .reg_dat_do (reg_dat_do),
    .reg_dat_re (reg_dat_re),
    .byte_valid (byteValid),
    .byte_data  (byteData)
  );

  // Parser, memory access and transmit sequencing: next state and next output values.
  always_comb begin
    state_d    = state_q;
    isWr_d     = isWr_q;
    byteCnt_d  = byteCnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_d      = rsp_q;
    rspLast_d  = rspLast_q;
    txCnt_d    = txCnt_q;
    divWe_d    = 4'h0;
    divDi_d    = 32'h0;
    datWe_d    = datWe_q;
    datDi_d    = datDi_q;
    memValid_d = memValid_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    memWstrb_d = memWstrb_q;
`ifdef UART_BRIDGE_TIMEOUT_EN
    tmo_d      = 32'h0;
`endif

    case (state_q)
      S_INIT: begin
        divWe_d = 4'hF;
        divDi_d = 32'(DIVIDER);
        state_d = S_CMD;
      end

      S_CMD: begin
        if (byteValid) begin
          byteCnt_d = 2'd0;
          if (byteData == CMD_RD) begin
            isWr_d  = 1'b0;
            state_d = S_ADDR;
          end else if (byteData == CMD_WR) begin
            isWr_d  = 1'b1;
            state_d = S_ADDR;
          end else begin
            rsp_d     = {24'h0, RSP_ERR};
            rspLast_d = 2'd0;
            txCnt_d   = 2'd0;
            datWe_d   = 1'b1;
            datDi_d   = RSP_ERR;
            state_d   = S_TX;
          end
        end
      end

      S_ADDR: begin
        if (byteValid) begin
          addr_d    = addrShift;
          byteCnt_d = byteCnt_q + 2'd1;
          if (byteCnt_q == 2'd3) begin
            if (isWr_q) begin
              state_d = S_DATA;
            end else begin
              memValid_d = 1'b1;
              memAddr_d  = {addrShift[31:2], 2'b00};
              memWstrb_d = 4'h0;
              state_d    = S_MEM;
            end
          end
        end
      end

      S_DATA: begin
        if (byteValid) begin
          wdata_d   = wdataShift;
          byteCnt_d = byteCnt_q + 2'd1;
          if (byteCnt_q == 2'd3) begin
            memValid_d = 1'b1;
            memAddr_d  = {addr_q[31:2], 2'b00};
            memWdata_d = wdataShift;
            memWstrb_d = 4'hF;
            state_d    = S_MEM;
          end
        end
      end

      S_MEM: begin
        if (mem_ready) begin
          memValid_d = 1'b0;
          memWstrb_d = 4'h0;
          txCnt_d    = 2'd0;
          datWe_d    = 1'b1;
          state_d    = S_TX;
          if (isWr_q) begin
            rsp_d     = {24'h0, RSP_ACK};
            rspLast_d = 2'd0;
            datDi_d   = RSP_ACK;
          end else begin
            rsp_d     = mem_rdata;
            rspLast_d = 2'd3;
            datDi_d   = mem_rdata[7:0];
          end
        end
      end

      S_TX: begin
        if (datWe_q) begin
          if (!reg_dat_wait) begin
            datWe_d = 1'b0;
            if (txCnt_q == rspLast_q) begin
              state_d = S_CMD;
            end else begin
              txCnt_d = txCnt_q + 2'd1;
            end
          end
        end else begin
          datWe_d = 1'b1;
          datDi_d = pickByte(rsp_q, txCnt_q);
        end
      end

      default: state_d = S_INIT;
    endcase

`ifdef UART_BRIDGE_TIMEOUT_EN
    if ((state_q == S_ADDR) || (state_q == S_DATA)) begin
      if (byteValid) begin
        tmo_d = 32'h0;
      end else if (tmo_q >= 32'(TIMEOUT - 1)) begin
        tmo_d     = 32'h0;
        byteCnt_d = 2'd0;
        state_d   = S_CMD;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end
`endif
  end

  // State and registered-output update; reset clears everything including outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_INIT;
      isWr_q     <= 1'b0;
      byteCnt_q  <= 2'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rsp_q      <= 32'h0;
      rspLast_q  <= 2'd0;
      txCnt_q    <= 2'd0;
      divWe_q    <= 4'h0;
      divDi_q    <= 32'h0;
      datWe_q    <= 1'b0;
      datDi_q    <= 8'h0;
      memValid_q <= 1'b0;
      memAddr_q  <= 32'h0;
      memWdata_q <= 32'h0;
      memWstrb_q <= 4'h0;
`ifdef UART_BRIDGE_TIMEOUT_EN
      tmo_q      <= 32'h0;
`endif
    end else begin
      state_q    <= state_d;
      isWr_q     <= isWr_d;
      byteCnt_q  <= byteCnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_q      <= rsp_d;
      rspLast_q  <= rspLast_d;
      txCnt_q    <= txCnt_d;
      divWe_q    <= divWe_d;
      divDi_q    <= divDi_d;
      datWe_q    <= datWe_d;
      datDi_q    <= datDi_d;
      memValid_q <= memValid_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      memWstrb_q <= memWstrb_d;
`ifdef UART_BRIDGE_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign reg_div_we = divWe_q;
  assign reg_div_di = divDi_q;
  assign reg_dat_we = datWe_q;
  assign reg_dat_di = {24'h0, datDi_q};
  assign mem_valid  = memValid_q;
  assign mem_addr   = memAddr_q;
  assign mem_wdata  = memWdata_q;
  assign mem_wstrb  = memWstrb_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Testbench for uart_mem_bridge: a UART model feeds command bytes and accepts
// reply bytes with random busy stalls, a memory model answers with random
// wait states, and scoreboard queues hold the expected accesses and replies.
// The timeout scenario is only exercised when UART_BRIDGE_TIMEOUT_EN is defined.
module tb_uart_mem_bridge;

  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  reg_div_we;
  logic [31:0] reg_div_di;
  logic        reg_dat_we;
  logic        reg_dat_re;
  logic [31:0] reg_dat_di;
  logic [31:0] reg_dat_do = 32'hFFFF_FFFF;
  logic        reg_dat_wait = 1'b0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;

  uart_mem_bridge #(.DIVIDER(DIV), .TIMEOUT(100)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .reg_div_we   (reg_div_we),
    .reg_div_di   (reg_div_di),
    .reg_dat_we   (reg_dat_we),
    .reg_dat_re   (reg_dat_re),
    .reg_dat_di   (reg_dat_di),
    .reg_dat_do   (reg_dat_do),
    .reg_dat_wait (reg_dat_wait),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } memReq_t;

  int          nChecks = 0;
  int          nPass = 0;
  logic [7:0]  rxQ[$];
  logic [7:0]  txExp[$];
  memReq_t     memExp[$];
  logic [31:0] memArr[logic [31:0]];
  logic [31:0] refMem[logic [31:0]];
  int          memCount = 0;
  int          txCount = 0;
  int          forceWait = -1;
  int          staleLeft = 0;
  logic [7:0]  staleByte = 8'h00;
  logic        reWasHigh = 1'b0;

  // Contents of never-written memory: an arbitrary but fixed function of the address.
  function automatic logic [31:0] defaultWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] memRead(input logic [31:0] a);
    return memArr.exists(a) ? memArr[a] : defaultWord(a);
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : defaultWord(a);
  endfunction

  function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endfunction

  // UART receive model: presents the head byte, and after a consume keeps
  // showing the consumed byte for one more cycle like the real valid flag.
  always @(negedge clk) begin
    if (reWasHigh) checkOutput("rePulseWidth", {31'b0, reg_dat_re}, 32'd0);
    reWasHigh = reg_dat_re;
    if (reg_dat_re) begin
      checkOutput("reWithByte", {31'b0, rxQ.size() != 0}, 32'd1);
      if (rxQ.size() != 0) begin
        staleByte = rxQ.pop_front();
        staleLeft = 2;
      end
    end
    if (staleLeft > 0) begin
      reg_dat_do = {24'h0, staleByte};
      staleLeft--;
    end else begin
      reg_dat_do = (rxQ.size() != 0) ? {24'h0, rxQ[0]} : 32'hFFFF_FFFF;
    end
  end

  // UART transmit model: random busy stalls, checks hold, gap and byte order.
  logic       prevHeld = 1'b0;
  logic       prevAccepted = 1'b0;
  logic [7:0] heldByte = 8'h00;
  logic [7:0] expByte;
  always @(negedge clk) begin
    if (!resetn) begin
      reg_dat_wait = 1'b0;
      prevHeld     = 1'b0;
      prevAccepted = 1'b0;
    end else begin
      if (prevHeld) checkOutput("txHoldDuringWait", {23'b0, reg_dat_we, reg_dat_di[7:0]}, {23'b0, 1'b1, heldByte});
      if (prevAccepted) checkOutput("txGap", {31'b0, reg_dat_we}, 32'd0);
      prevHeld     = 1'b0;
      prevAccepted = 1'b0;
      if (reg_dat_we) begin
        reg_dat_wait = ($urandom_range(0, 2) == 0);
        if (reg_dat_wait) begin
          prevHeld = 1'b1;
          heldByte = reg_dat_di[7:0];
        end else begin
          prevAccepted = 1'b1;
          txCount++;
          checkOutput("txExpected", {31'b0, txExp.size() != 0}, 32'd1);
          if (txExp.size() != 0) begin
            expByte = txExp.pop_front();
            checkOutput("txByte", reg_dat_di, {24'h0, expByte});
          end
        end
      end else begin
        reg_dat_wait = 1'b0;
      end
    end
  end

  // Memory slave model: random wait states, checks request against scoreboard and stability.
  logic        inAccess = 1'b0;
  int          waitLeft = 0;
  logic [31:0] heldAddr, heldWdata;
  logic [3:0]  heldWstrb;
  memReq_t     expReq;
  always @(negedge clk) begin
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    if (!resetn) begin
      inAccess = 1'b0;
    end else if (mem_valid) begin
      if (!inAccess) begin
        inAccess  = 1'b1;
        memCount++;
        waitLeft  = (forceWait >= 0) ? forceWait : int'($urandom_range(0, 3));
        heldAddr  = mem_addr;
        heldWdata = mem_wdata;
        heldWstrb = mem_wstrb;
        checkOutput("memExpected", {31'b0, memExp.size() != 0}, 32'd1);
        if (memExp.size() != 0) begin
          expReq = memExp.pop_front();
          checkOutput("memAddr", mem_addr, expReq.addr);
          checkOutput("memWstrb", {28'h0, mem_wstrb}, {28'h0, expReq.wstrb});
          if (expReq.wstrb == 4'hF) checkOutput("memWdata", mem_wdata, expReq.wdata);
        end
      end else begin
        checkOutput("memAddrStable", mem_addr, heldAddr);
        checkOutput("memWdataStable", mem_wdata, heldWdata);
        checkOutput("memWstrbStable", {28'h0, mem_wstrb}, {28'h0, heldWstrb});
      end
      if (waitLeft == 0) begin
        mem_ready = 1'b1;
        mem_rdata = memRead(mem_addr);
        if (mem_wstrb == 4'hF) memArr[mem_addr] = mem_wdata;
        inAccess = 1'b0;
      end else begin
        waitLeft--;
      end
    end
  end

  // Queue one command's bytes and its expected memory access and reply.
  // kind: 0 read, 1 write, 2 unknown command byte.
  task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [31:0] data,
                               input logic [7:0] badByte);
    logic [31:0] wa;
    logic [31:0] rd;
    memReq_t     r;
    wa = {addr[31:2], 2'b00};
    if (kind == 2) begin
      txExp.push_back(8'h3F);
      rxQ.push_back(badByte);
    end else begin
      r.addr  = wa;
      r.wdata = (kind == 1) ? data : 32'h0;
      r.wstrb = (kind == 1) ? 4'hF : 4'h0;
      memExp.push_back(r);
      if (kind == 1) begin
        refMem[wa] = data;
        txExp.push_back(8'h2E);
      end else begin
        rd = refRead(wa);
        for (int i = 0; i < 4; i++) txExp.push_back(rd[8*i +: 8]);
      end
      rxQ.push_back((kind == 1) ? 8'h57 : 8'h52);
      for (int i = 0; i < 4; i++) rxQ.push_back(addr[8*i +: 8]);
      if (kind == 1) for (int i = 0; i < 4; i++) rxQ.push_back(data[8*i +: 8]);
    end
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while ((rxQ.size() != 0 || txExp.size() != 0 || memExp.size() != 0 || staleLeft != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "Completes"}, {31'b0, n < 2000}, 32'd1);
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".reg_div_we"}, {28'h0, reg_div_we}, 32'd0);
    checkOutput({tag, ".reg_div_di"}, reg_div_di, 32'd0);
    checkOutput({tag, ".reg_dat_we"}, {31'b0, reg_dat_we}, 32'd0);
    checkOutput({tag, ".reg_dat_re"}, {31'b0, reg_dat_re}, 32'd0);
    checkOutput({tag, ".reg_dat_di"}, reg_dat_di, 32'd0);
    checkOutput({tag, ".mem_valid"}, {31'b0, mem_valid}, 32'd0);
    checkOutput({tag, ".mem_addr"}, mem_addr, 32'd0);
    checkOutput({tag, ".mem_wdata"}, mem_wdata, 32'd0);
    checkOutput({tag, ".mem_wstrb"}, {28'h0, mem_wstrb}, 32'd0);
  endtask

  task automatic checkDividerWrite(input string tag);
    @(negedge clk);
    checkOutput({tag, ".divWe"}, {28'h0, reg_div_we}, 32'h0000_000F);
    checkOutput({tag, ".divDi"}, reg_div_di, DIV);
    checkOutput({tag, ".memValidLow"}, {31'b0, mem_valid}, 32'd0);
    checkOutput({tag, ".datWeLow"}, {31'b0, reg_dat_we}, 32'd0);
    @(negedge clk);
    checkOutput({tag, ".divWeOneCycle"}, {28'h0, reg_div_we}, 32'd0);
    checkOutput({tag, ".divDiCleared"}, reg_div_di, 32'd0);
    #1;
  endtask

  // Global time bound so the run always terminates.
  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got %0d/%0d", nPass, nChecks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized commands.
  initial begin
    int m, t, n, kind;
    logic [31:0] a, d;
    logic [7:0] bad;

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    #1 resetn = 1'b1;
    checkDividerWrite("init");

    m = memCount;
    applyStimulus(1, 32'h0000_0010, 32'hDEAD_BEEF, 8'h00);
    waitIdle("write");
    checkOutput("writeAccessCount", memCount - m, 32'd1);

    memArr[32'h10] = 32'h1234_5678;
    refMem[32'h10] = 32'h1234_5678;
    forceWait = 5;
    applyStimulus(0, 32'h0000_0013, 32'h0, 8'h00);
    waitIdle("read");
    forceWait = -1;

    m = memCount;
    applyStimulus(2, 32'h0, 32'h0, 8'h41);
    waitIdle("badCmd");
    checkOutput("badCmdNoAccess", memCount - m, 32'd0);
    applyStimulus(0, 32'h0000_0010, 32'h0, 8'h00);
    waitIdle("readAfterBad");

`ifdef UART_BRIDGE_TIMEOUT_EN
    m = memCount;
    t = txCount;
    rxQ.push_back(8'h52);
    rxQ.push_back(8'h10);
    repeat (150) @(negedge clk);
    checkOutput("timeoutNoAccess", memCount - m, 32'd0);
    checkOutput("timeoutNoReply", txCount - t, 32'd0);
    #1;
    applyStimulus(1, 32'h0000_0020, 32'hCAFE_F00D, 8'h00);
    waitIdle("afterTimeout");
`endif

    forceWait = 40;
    applyStimulus(0, 32'h0000_0044, 32'h0, 8'h00);
    n = 0;
    while (!mem_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midAccessReached", {31'b0, mem_valid}, 32'd1);
    #1 resetn = 1'b0;
    @(negedge clk);
    checkAllZero("midReset");
    #1;
    txExp.delete();
    memExp.delete();
    rxQ.delete();
    forceWait = -1;
    resetn = 1'b1;
    checkDividerWrite("reinit");

    for (int i = 0; i < 25; i++) begin
      n = $urandom_range(0, 9);
      kind = (n < 4) ? 1 : ((n < 8) ? 0 : 2);
      a = ($urandom_range(0, 3) == 0) ? $urandom : {24'h0, 8'($urandom_range(0, 63))};
      d = $urandom;
      bad = 8'($urandom_range(0, 255));
      while (bad == 8'h52 || bad == 8'h57) bad = 8'($urandom_range(0, 255));
      applyStimulus(kind, a, d, bad);
      waitIdle("random");
    end

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/uart_mem_bridge.md
# uart_mem_bridge

UART debug bridge that turns byte commands arriving through the simple UART's register port into 32-bit memory reads and writes. It is the initiator on the UART register interface: it programs the divider, polls and consumes received bytes, and pushes response bytes. On the other side it masters the PicoRV32-style native memory bus into the HyperBUS controller or SoC interconnect, so a host PC can peek and poke memory without the CPU.

## Interface
- `DIVIDER`, default 104: UART clock divider, written once after reset.
- `TIMEOUT`, default 1_000_000: inter-byte timeout in clk cycles; used only with the macro in Configuration.
- `clk` in 1: single clock.
- `resetn` in 1: reset; synchronous, active-low.
- `reg_div_we` out 4: divider byte-write enables to UART.
- `reg_div_di` out 32: divider value.
- `reg_dat_we` out 1: transmit request.
- `reg_dat_re` out 1: receive-buffer consume pulse.
- `reg_dat_di` out 32: transmit byte in [7:0]; [31:8] are 0.
- `reg_dat_do` in 32: received byte in [7:0], or 32'hFFFFFFFF when empty.
- `reg_dat_wait` in 1: UART transmitter busy; holds the current write.
- `mem_valid` out 1: memory request.
- `mem_ready` in 1: memory completion.
- `mem_addr` out 32: word address; [1:0] are always 0.
- `mem_wdata` out 32: write data.
- `mem_wstrb` out 4: 4'hF for writes, 0 for reads.
- `mem_rdata` in 32: read data, valid when `mem_ready` is high.

## Operation
- Reset value of every output is 0. All internal registers are cleared.
- **S_INIT** (one cycle after reset release): drive `reg_div_we`=4'hF and `reg_div_di`=DIVIDER, then go to S_CMD.
- **RX poll** (S_CMD, S_ADDR, S_DATA):
  - A byte is present when `reg_dat_do` != 32'hFFFFFFFF. Capture [7:0] and pulse `reg_dat_re` for 1 cycle.
  - The cycle after the pulse is a mandatory skip cycle with no sampling, because the UART valid flag clears one cycle late.
- **S_CMD**:
  - 0x52 'R' → S_ADDR with `is_wr`=0.
  - 0x57 'W' → S_ADDR with `is_wr`=1.
  - Any other byte → queue response 0x3F, then S_TX.
- **S_ADDR**: collect 4 bytes, LSB first, into the address register. After byte 3: 'W' → S_DATA, 'R' → S_MEM.
- **S_DATA**: collect 4 bytes, LSB first, into wdata. Then → S_MEM.
- **S_MEM**:
  - Assert `mem_valid` with addr = {addr[31:2], 2'b00}.
  - `mem_valid`, `mem_addr`, `mem_wdata` and `mem_wstrb` are stable until the cycle `mem_ready`=1.
  - On that cycle deassert `mem_valid` next cycle and latch `mem_rdata` for reads.
  - Queue the response: read → 4 bytes of rdata, LSB first; write → single byte 0x2E '.'.
  - Then → S_TX.
- **S_TX**:
  - Drive `reg_dat_we`=1 with the current byte.
  - A byte is accepted on a cycle with `reg_dat_we`=1 and `reg_dat_wait`=0. Advance the 2-bit byte counter after acceptance.
  - Deassert `reg_dat_we` for at least 1 cycle between bytes.
  - After the last byte → S_CMD.
- Bytes received during S_MEM or S_TX are left in the UART and are not consumed.
- No pipelining: only one command is in flight at a time.

## Timing
- Divider write occurs in the first cycle after `resetn` rises.
- Earliest `mem_valid` is 1 cycle after the `reg_dat_re` of the final address or data byte.
- If memory has zero wait, `mem_ready` in the same cycle as `mem_valid` ends the access in 1 cycle.
- The first response byte is presented the cycle after `mem_ready`.
- A `resetn` low mid-operation aborts everything at the next edge. No memory-side cleanup is done; the memory slave must tolerate `mem_valid` dropping.

## Configuration
- **`UART_BRIDGE_TIMEOUT_EN` defined**:
  - A 32-bit counter runs in S_ADDR and S_DATA. It clears on every consumed byte.
  - Reaching TIMEOUT returns the parser to S_CMD silently, with no response and no memory access.
- **Undefined**: no counter; the parser waits for bytes indefinitely.

## Structure
- **Shared package `uart_bridge_pkg`** holds:
  - the state enum (S_INIT, S_CMD, S_ADDR, S_DATA, S_MEM, S_TX);
  - command constants CMD_RD=8'h52 and CMD_WR=8'h57;
  - response constants RSP_ACK=8'h2E and RSP_ERR=8'h3F.
- **Sub-module `uart_bridge_rxpoll`**: the RX poll/consume/skip logic, with a byte_valid/byte_data output. Everything else stays in the top level.

## Test plan
- **Reset and divider**: reset, DIVIDER=8 → one-cycle `reg_div_we`=4'hF, `reg_div_di`=8; all other outputs 0.
- **Write**: bytes 57 10 00 00 00 EF BE AD DE → one access with `mem_addr`=0x10, `mem_wdata`=0xDEADBEEF, `mem_wstrb`=F; UART transmits 0x2E.
- **Read**: memory returns 0x12345678 after 5 wait cycles for bytes 52 13 00 00 00 → `mem_addr`=0x10, `mem_wstrb`=0; UART transmits 78 56 34 12, and each `reg_dat_we` is held while `reg_dat_wait`=1.
- **Bad command**: byte 0x41 → 0x3F transmitted, no `mem_valid`; a following valid 'R' command still works.
- **Timeout** (`UART_BRIDGE_TIMEOUT_EN`, TIMEOUT=100): send 52 10, then idle 150 cycles → no response and no access; the next full command succeeds.
- **Reset mid-access**: assert `resetn`=0 while `mem_valid`=1 → all outputs 0 next cycle, then the divider write repeats after release.
